// File: rtl/game_autoplayer_if.sv
// game_autoplayer_if: script load, playthrough control, game pins and status of the autoplayer.
interface game_autoplayer_if #(parameter int DEPTH = 16);
  localparam int CW = $clog2(DEPTH + 1);
  logic          load_valid;
  logic [1:0]    load_data;
  logic          load_ready;
  logic          clear;
  logic          start;
  logic          game_reset;
  logic          N, S, E, W;
  logic          WIN, DIE;
  logic          busy;
  logic          done;
  logic [1:0]    outcome;
  logic [CW-1:0] count;
  logic [CW-1:0] moves_used;
  modport master (
    output load_valid, load_data, clear, start, WIN, DIE,
    input  load_ready, game_reset, N, S, E, W, busy, done, outcome, count, moves_used
  );
  modport slave (
    input  load_valid, load_data, clear, start, WIN, DIE,
    output load_ready, game_reset, N, S, E, W, busy, done, outcome, count, moves_used
  );
endinterface

// File: rtl/game_autoplayer.sv
// game_autoplayer: replays a stored N/S/E/W script into the game and reports WIN/DIE/timeout.
module game_autoplayer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 8
) (
  input logic              clk,
  input logic              reset,
  game_autoplayer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GRST, DRIVE, GAP, DRAIN, DONE} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d, rptr_q, rptr_d, moves_q, moves_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          gcnt_q, gcnt_d;
  logic [3:0]    dir_q, dir_d;
  logic          grst_q, grst_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]    out_q, out_d;
  logic [1:0]    script_q [DEPTH];
  logic          idle, ready, load, go, hit;
  logic [1:0]    code, hit_code;
  always_comb begin
    idle     = state_q == IDLE || state_q == DONE;
    ready    = idle && count_q < CW'(DEPTH);
    load     = bus.load_valid && ready && !bus.clear;
    count_d  = (idle && bus.clear) ? '0 : load ? count_q + 1'b1 : count_q;
    go       = idle && bus.start && count_d != '0;
    hit      = bus.WIN || bus.DIE;
    hit_code = bus.DIE ? 2'b10 : 2'b01;
    state_d  = state_q;
    rptr_d   = rptr_q;
    moves_d  = moves_q;
    timer_d  = timer_q;
    gcnt_d   = gcnt_q;
    out_d    = out_q;
    case (state_q)
      IDLE, DONE: if (go) begin
        state_d = GRST;
        gcnt_d  = 1'b0;
        rptr_d  = '0;
        moves_d = '0;
        out_d   = 2'b00;
      end
      GRST: begin
        gcnt_d  = 1'b1;
        state_d = gcnt_q ? DRIVE : GRST;
      end
      DRIVE: begin
        rptr_d  = rptr_q + 1'b1;
        moves_d = moves_q + 1'b1;
        state_d = hit ? DONE : GAP;
        out_d   = hit ? hit_code : out_q;
      end
      GAP: begin
        timer_d = '0;
        state_d = hit ? DONE : (rptr_q == count_q) ? DRAIN : DRIVE;
        out_d   = hit ? hit_code : out_q;
      end
      DRAIN: begin
        timer_d = timer_q + 1'b1;
        state_d = (hit || timer_q == TW'(TIMEOUT - 1)) ? DONE : DRAIN;
        out_d   = hit ? hit_code : (timer_q == TW'(TIMEOUT - 1)) ? 2'b11 : out_q;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so every pin comes straight off a flop.
    code   = script_q[rptr_d[AW-1:0]];
    dir_d  = (state_d == DRIVE) ? 4'b1000 >> code : 4'b0000;
    grst_d = state_d == GRST;
    busy_d = state_d inside {GRST, DRIVE, GAP, DRAIN};
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rptr_q  <= '0;
      moves_q <= '0;
      timer_q <= '0;
      gcnt_q  <= 1'b0;
      dir_q   <= 4'b0000;
      grst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      moves_q <= moves_d;
      timer_q <= timer_d;
      gcnt_q  <= gcnt_d;
      dir_q   <= dir_d;
      grst_q  <= grst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (load) script_q[count_q[AW-1:0]] <= bus.load_data;
  end
  assign bus.load_ready = ready;
  assign bus.N          = dir_q[3];
  assign bus.S          = dir_q[2];
  assign bus.E          = dir_q[1];
  assign bus.W          = dir_q[0];
  assign bus.game_reset = grst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.outcome    = out_q;
  assign bus.count      = count_q;
  assign bus.moves_used = moves_q;
endmodule

// File: tb/tb_game_autoplayer.sv
// tb_game_autoplayer: directed vector table plus hand sequences for timeout, depth, guards and async reset.
module tb_game_autoplayer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  game_autoplayer_if #(.DEPTH(16)) bus();
  game_autoplayer #(.DEPTH(16), .TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic       lv;
    logic [1:0] ld;
    logic       clr, st, win, die;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [1:0] codes [4];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask
  function automatic logic [19:0] obs();
    return {bus.N, bus.S, bus.E, bus.W, bus.game_reset, bus.busy, bus.done, bus.outcome,
            bus.count, bus.moves_used, bus.load_ready};
  endfunction
  task automatic add(input int lv, ld, clr, st, win, die, dir, grst, busy, done, out, cnt, mv, rdy);
    vec_t t;
    t.lv = lv[0]; t.ld = ld[1:0]; t.clr = clr[0]; t.st = st[0]; t.win = win[0]; t.die = die[0];
    t.exp = {dir[3:0], grst[0], busy[0], done[0], out[1:0], cnt[4:0], mv[4:0], rdy[0]};
    tbl.push_back(t);
  endtask
  task automatic load(input logic [1:0] c);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = c;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
  endtask
  // Start from IDLE/DONE with script W,W,N,S loaded; no WIN/DIE so it must time out.
  task automatic play_timeout(input string tag);
    logic [3:0] e;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e = (c >= 3 && c <= 9 && (c - 3) % 2 == 0) ? 4'b1000 >> codes[(c - 3) / 2] : 4'b0000;
      chk($sformatf("%s_c%0d", tag, c), {bus.N, bus.S, bus.E, bus.W, bus.game_reset, bus.busy, bus.done},
          {e, c <= 2, c <= 18, c == 19});
    end
    chk({tag, "_outcome"}, bus.outcome, 2'b11);
    chk({tag, "_moves"}, bus.moves_used, 4);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    bit found;
    bus.load_valid = 1'b0; bus.load_data = 2'b00; bus.clear = 1'b0;
    bus.start = 1'b0; bus.WIN = 1'b0; bus.DIE = 1'b0;
    codes[0] = 2'd3; codes[1] = 2'd3; codes[2] = 2'd0; codes[3] = 2'd1;
    //   lv ld clr st win die | dir grst busy done out cnt mv rdy
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 1);
    add(1, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0, 1);
    add(1, 2, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 0, 1);
    add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4, 0, 1);
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 1, 0, 0,   8, 0, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 4, 2, 0);
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 4, 2, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 4, 3, 0);
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 4, 3, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 4, 3, 1);
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0,   8, 0, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 4, 2, 0);
    add(0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 2, 4, 2, 1);
    add(1, 3, 1, 0, 0, 0,   0, 0, 0, 1, 2, 0, 2, 1);
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 2, 0, 2, 1);
    add(1, 3, 0, 1, 0, 0,   0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 2, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_state", obs(), 20'h00001);
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.load_valid = tbl[i].lv; bus.load_data = tbl[i].ld; bus.clear = tbl[i].clr;
      bus.start = tbl[i].st; bus.WIN = tbl[i].win; bus.DIE = tbl[i].die;
      @(posedge clk); #1;
      chk($sformatf("row%0d", i), obs(), tbl[i].exp);
    end
    @(negedge clk);
    bus.load_valid = 1'b0; bus.clear = 1'b1; bus.start = 1'b0; bus.WIN = 1'b0; bus.DIE = 1'b0;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    chk("clear_done", bus.count, 0);
    for (int i = 0; i < 4; i++) load(codes[i]);
    play_timeout("timeout1");
    play_timeout("replay");
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data  = 2'(i);
      chk($sformatf("ready_%0d", i), bus.load_ready, i < 16);
      @(posedge clk); #1;
      chk($sformatf("count_%0d", i), bus.count, (i < 16) ? i + 1 : 16);
    end
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.load_valid = 1'b0;
    chk("clear_beats_load", {bus.count, bus.load_ready}, 1);
    load(2'd0);
    load(2'd2);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #1;
      found = {bus.N, bus.S, bus.E, bus.W} != 4'b0000;
    end
    chk("reach_drive", found, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset", obs(), 20'h00001);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("empty_start_%0d", k), {bus.busy, bus.game_reset, bus.done}, 0);
    end
    bus.start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
